// File: rtl/tdm_demux2.sv
// tdm_demux2: two-slot serial TDM demultiplexer with frame-sync tracking.
// The serial line carries data MSB first. Slot 0 comes first, then slot 1, with no gap between them.
// Lock is dropped after MISS_MAX consecutive frame boundaries that arrive without fsync.
// Optional feature: define TDM_PARITY_EN to expect one trailing even-parity bit per slot.
module tdm_demux2 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             fsync,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic             v0,
    output logic             v1,
    output logic             locked,
    output logic             err
);

`ifdef TDM_PARITY_EN
    localparam int unsigned SlotLen = WIDTH + 1;
`else
    localparam int unsigned SlotLen = WIDTH;
`endif
    localparam int unsigned CntW  = $clog2(SlotLen);
    localparam int unsigned MissW = $clog2(MISS_MAX + 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(SlotLen - 1);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [MissW-1:0] MissLast = MissW'(MISS_MAX - 1);

    typedef enum logic [1:0] {StHunt, StSlot0, StSlot1} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [MissW-1:0]     miss_q, miss_d;
    logic [SlotLen-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]     y0_q, y0_d, y1_q, y1_d;
    logic                 v0_q, v0_d, v1_q, v1_d, err_q, err_d;

    logic [SlotLen-1:0]   word;
    logic [WIDTH-1:0]     data;
    logic                 slot_ok;
    logic                 boundary;
    logic                 last;

    // The slot word includes the bit that is on the line in the current cycle.
    assign word     = {sr_q[SlotLen-2:0], din};
    assign boundary = (state_q == StSlot0) && (cnt_q == '0);
    assign last     = (cnt_q == CntLast);
`ifdef TDM_PARITY_EN
    assign data     = word[SlotLen-1:1];
    assign slot_ok  = ~^word;
`else
    assign data     = word;
    assign slot_ok  = 1'b1;
`endif

    // State, counters, output words and pulses. Reset is synchronous and has highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHunt;
            cnt_q   <= '0;
            miss_q  <= '0;
            sr_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            sr_q    <= sr_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic covers hunting, slot assembly, realignment on fsync, and miss tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        sr_d    = sr_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StHunt: begin
                if (fsync) begin
                    sr_d    = word;
                    state_d = StSlot0;
                    cnt_d   = CntOne;
                    miss_d  = '0;
                end
            end
            StSlot0, StSlot1: begin
                sr_d = word;
                if (fsync && !boundary) begin
                    // A misplaced fsync aborts the current slot and starts a new slot 0 on this bit.
                    err_d   = 1'b1;
                    state_d = StSlot0;
                    cnt_d   = CntOne;
                    miss_d  = '0;
                end else if (boundary && !fsync && (miss_q >= MissLast)) begin
                    err_d   = 1'b1;
                    state_d = StHunt;
                    cnt_d   = '0;
                    miss_d  = '0;
                end else begin
                    if (boundary) begin
                        miss_d = fsync ? '0 : miss_q + MissW'(1);
                    end
                    if (last) begin
                        cnt_d   = '0;
                        state_d = (state_q == StSlot0) ? StSlot1 : StSlot0;
                        if (!slot_ok) begin
                            err_d = 1'b1;
                        end else if (state_q == StSlot0) begin
                            y0_d = data;
                            v0_d = 1'b1;
                        end else begin
                            y1_d = data;
                            v1_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            default: begin
                state_d = StHunt;
                cnt_d   = '0;
            end
        endcase
    end

    assign Y0     = y0_q;
    assign Y1     = y1_q;
    assign v0     = v0_q;
    assign v1     = v1_q;
    assign err    = err_q;
    assign locked = (state_q != StHunt);

endmodule

// File: tb/tb_tdm_demux2.sv
// Testbench for tdm_demux2. It runs directed frame scenarios followed by randomized frames.
// Each run is checked against a frame-position reference model. Honours TDM_PARITY_EN.
module tb_tdm_demux2;

    localparam int unsigned W  = 8;
    localparam int unsigned MM = 2;
`ifdef TDM_PARITY_EN
    localparam int unsigned L = W + 1;
`else
    localparam int unsigned L = W;
`endif

    logic         clk = 1'b0;
    logic         rst, din, fsync;
    logic [W-1:0] Y0, Y1;
    logic         v0, v1, locked, err;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: frame position 0..2L-1 while aligned
    bit          aligned = 1'b0;
    int          pos = 0;
    int          miss = 0;
    int unsigned acc = 0;
    logic [W-1:0] e_y0 = '0, e_y1 = '0;
    logic        e_v0 = 1'b0, e_v1 = 1'b0, e_err = 1'b0;

    always #5 clk = ~clk;

    tdm_demux2 #(.WIDTH(W), .MISS_MAX(MM)) dut (
        .clk(clk), .rst(rst), .din(din), .fsync(fsync),
        .Y0(Y0), .Y1(Y1), .v0(v0), .v1(v1), .locked(locked), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic d, input logic fs, input logic r);
        bit ok;
        logic [W-1:0] dat;
        e_v0 = 1'b0; e_v1 = 1'b0; e_err = 1'b0;
        if (r) begin
            aligned = 1'b0; pos = 0; miss = 0; acc = 0; e_y0 = '0; e_y1 = '0;
        end else if (!aligned) begin
            if (fs) begin aligned = 1'b1; pos = 1; acc = 32'(d); miss = 0; end
        end else if (fs && pos != 0) begin
            e_err = 1'b1; pos = 1; acc = 32'(d); miss = 0;
        end else if (pos == 0 && !fs && miss + 1 >= MM) begin
            aligned = 1'b0; e_err = 1'b1; pos = 0; miss = 0;
        end else begin
            if (pos == 0) miss = fs ? 0 : miss + 1;
            acc = (pos % L == 0) ? 32'(d) : ((acc << 1) | 32'(d));
            if (pos % L == L - 1) begin
`ifdef TDM_PARITY_EN
                ok  = ((^acc[L-1:0]) == 1'b0);
                dat = acc[L-1:1];
`else
                ok  = 1'b1;
                dat = acc[W-1:0];
`endif
                if (!ok) e_err = 1'b1;
                else if (pos < L) begin e_y0 = dat; e_v0 = 1'b1; end
                else begin e_y1 = dat; e_v1 = 1'b1; end
            end
            pos = (pos + 1) % (2 * L);
        end
    endtask

    task automatic step(input logic d, input logic fs, input logic r);
        din = d; fsync = fs; rst = r;
        @(posedge clk);
        model(d, fs, r);
        #1;
        chk("Y0", 32'(Y0), 32'(e_y0));
        chk("Y1", 32'(Y1), 32'(e_y1));
        chk("v0", 32'(v0), 32'(e_v0));
        chk("v1", 32'(v1), 32'(e_v1));
        chk("err", 32'(err), 32'(e_err));
        chk("locked", 32'(locked), 32'(aligned));
    endtask

    // one slot of data; bad flips the parity bit when parity is compiled in
    task automatic send_slot(input logic [W-1:0] dv, input bit fs, input bit bad);
        for (int i = 0; i < W; i++) step(dv[W-1-i], fs && (i == 0), 1'b0);
`ifdef TDM_PARITY_EN
        step((^dv) ^ bad, 1'b0, 1'b0);
`else
        if (bad) begin end
`endif
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; fsync = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_locked", 32'(locked), 32'd0);

        // hunt ignores din without fsync
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0, 1'b0);

        // normal frame
        send_slot(8'hA5, 1'b1, 1'b0);
        chk("y0_a5", 32'(Y0), 32'hA5);
        chk("v0_a5", 32'(v0), 32'd1);
        send_slot(8'h3C, 1'b0, 1'b0);
        chk("y1_3c", 32'(Y1), 32'h3C);

        // back-to-back frames
        send_slot(8'h01, 1'b1, 1'b0);
        send_slot(8'h02, 1'b0, 1'b0);
        send_slot(8'hFF, 1'b1, 1'b0);
        send_slot(8'h00, 1'b0, 1'b0);
        chk("y0_ff", 32'(Y0), 32'hFF);

        // misplaced fsync at bit 3 of slot 1
        send_slot(8'h5A, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        send_slot(8'h77, 1'b1, 1'b0);
        chk("y0_77", 32'(Y0), 32'h77);
        send_slot(8'h12, 1'b0, 1'b0);

        // two missing fsyncs, then a frame while hunting, then relock
        send_slot(8'h33, 1'b0, 1'b0);
        send_slot(8'h44, 1'b0, 1'b0);
        chk("y0_33", 32'(Y0), 32'h33);
        send_slot(8'h55, 1'b0, 1'b0);
        chk("miss_unlocked", 32'(locked), 32'd0);
        send_slot(8'h66, 1'b0, 1'b0);
        send_slot(8'h99, 1'b1, 1'b0);
        send_slot(8'hC3, 1'b0, 1'b0);

        // reset at bit 4 of slot 0
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_y0", 32'(Y0), 32'd0);
        for (int i = 0; i < 12; i++) step(1'($urandom), 1'b0, 1'b0);
        send_slot(8'hE7, 1'b1, 1'b0);

        // parity: bad then good
        send_slot(8'h0F, 1'b0, 1'b0);
        send_slot(8'hA5, 1'b1, 1'b1);
        send_slot(8'h11, 1'b0, 1'b0);
        send_slot(8'hA5, 1'b1, 1'b0);
        chk("par_good_a5", 32'(Y0), 32'hA5);

        // randomized frames
        for (int f = 0; f < 300; f++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r < 13) begin
                send_slot(8'($urandom), 1'b1, ($urandom_range(0, 7) == 0));
                send_slot(8'($urandom), 1'b0, ($urandom_range(0, 7) == 0));
            end else if (r < 16) begin
                send_slot(8'($urandom), 1'b0, 1'b0);
                send_slot(8'($urandom), 1'b0, 1'b0);
            end else if (r < 19) begin
                for (int k = 0; k < int'($urandom_range(1, 2 * L - 1)); k++)
                    step(1'($urandom), 1'b0, 1'b0);
                send_slot(8'($urandom), 1'b1, 1'b0);
            end else begin
                step(1'($urandom), 1'($urandom), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
